// File: rtl/degamma_lut_builder_pkg.sv
// rtl/degamma_lut_builder_pkg.sv - shared constants and types for the inverse-gamma table builder
//
// Contents:
//   DATA_W_DEF    default pixel/table width
//   TABLE_DEPTH   number of inverse-table entries at the default width
//   build_state_t build FSM state encoding
package degamma_lut_builder_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int TABLE_DEPTH = 1 << DATA_W_DEF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_CMP  = 3'd2,
        ST_TAIL = 3'd3,
        ST_DONE = 3'd4
    } build_state_t;

endpackage

// File: rtl/degamma_ram.sv
// rtl/degamma_ram.sv - simple dual-port inverse-table RAM with registered read
//
// Ports:
//   clk, rst         clock, synchronous active-high reset (read register only)
//   wr_en/addr/data  write port, owned by the build FSM
//   rd_en/addr       read port, owned by the lookup pipeline
//   rd_data          registered read data; holds its value when rd_en is low
module degamma_ram
    import degamma_lut_builder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << DATA_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // The array itself is not reset; only the output register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/degamma_lut_builder.sv
// rtl/degamma_lut_builder.sv - builds an inverse gamma table from the forward ROM and serves lookups
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   build_start  one-cycle pulse that (re)starts a table build from any state
//   rom_addr     address to the external forward gamma ROM (1-cycle registered read)
//   rom_data     G(rom_addr) as sampled by the ROM at the previous edge
//   ready        table is complete and lookups are accepted
//   mono_err     sticky: forward table decreased somewhere during the last build
//   in_valid     pixel valid
//   in_data      gamma-encoded pixel
//   out_valid    lookup result valid, two cycles after acceptance
//   out_data     linearised pixel
//   drop_pulse   in_valid seen while ready is low; that pixel is discarded
module degamma_lut_builder
    import degamma_lut_builder_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter bit AUTO_BUILD = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              build_start,
    output logic [DATA_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              ready,
    output logic              mono_err,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              drop_pulse
);

    localparam logic [DATA_W-1:0] MAX_VAL = '1;
    localparam logic [DATA_W-1:0] X_ONE   = DATA_W'(1);
    localparam logic [DATA_W:0]   Y_ONE   = (DATA_W + 1)'(1);

    build_state_t      state, state_next;
    logic [DATA_W-1:0] x, x_next;
    logic [DATA_W:0]   y, y_next;       // one extra bit so the sweep end is representable
    logic [DATA_W-1:0] prev_g, prev_g_next;
    logic              mono_next;
    logic              auto_pending;
    logic              start_build;

    logic              wr_en;
    logic [DATA_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              accept;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_addr;

    // A build request from any state jumps straight into a cleared sweep,
    // which also covers a restart in the middle of a build.
    assign start_build = build_start | ((state == ST_IDLE) & auto_pending);

    assign ready      = (state == ST_DONE);
    assign rom_addr   = x;              // x only moves on CMP->REQ, so the address is held through CMP
    assign accept     = in_valid & ready;
    assign drop_pulse = in_valid & ~ready;

    // ------------------------------------------------------------------
    // Build FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            x            <= '0;
            y            <= '0;
            prev_g       <= '0;
            mono_err     <= 1'b0;
            auto_pending <= AUTO_BUILD;
        end else begin
            state    <= state_next;
            x        <= x_next;
            y        <= y_next;
            prev_g   <= prev_g_next;
            mono_err <= mono_next;
            if (start_build) begin
                auto_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next  = state;
        x_next      = x;
        y_next      = y;
        prev_g_next = prev_g;
        mono_next   = mono_err;
        wr_en       = 1'b0;
        wr_addr     = y[DATA_W-1:0];
        wr_data     = x;

        if (start_build) begin
            state_next  = ST_REQ;
            x_next      = '0;
            y_next      = '0;
            prev_g_next = '0;
            mono_next   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_next = ST_IDLE;
                end
                ST_REQ: begin
                    state_next = ST_CMP;
                end
                ST_CMP: begin
                    // rom_data stays G(x) for as long as we sit in CMP, so the
                    // previous-x comparison can be evaluated every CMP cycle.
                    if (rom_data < prev_g) begin
                        mono_next = 1'b1;
                    end
                    if (y <= {1'b0, rom_data}) begin
                        // x is the smallest input reaching level y
                        wr_en  = 1'b1;
                        y_next = y + Y_ONE;
                        if (y[DATA_W-1:0] == MAX_VAL) begin
                            state_next = ST_DONE;
                        end
                    end else if (x == MAX_VAL) begin
                        state_next = ST_TAIL;
                    end else begin
                        x_next      = x + X_ONE;
                        prev_g_next = rom_data;
                        state_next  = ST_REQ;
                    end
                end
                ST_TAIL: begin
                    // Levels above G(max) are never reached; saturate them.
                    wr_en   = 1'b1;
                    wr_data = MAX_VAL;
                    y_next  = y + Y_ONE;
                    if (y[DATA_W-1:0] == MAX_VAL) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_next = ST_DONE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Lookup pipeline: stage 1 captures the address, stage 2 is the RAM read
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            out_valid <= 1'b0;
        end else begin
            s1_valid  <= accept;
            if (accept) begin
                s1_addr <= in_data;
            end
            out_valid <= s1_valid;
        end
    end

    // The earliest table write after a build request lands two edges later,
    // so a pixel accepted alongside the request still reads the old contents.
    degamma_ram #(
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (s1_valid),
        .rd_addr (s1_addr),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_degamma_lut_builder.sv
// tb/tb_degamma_lut_builder.sv - self-checking bench for degamma_lut_builder
module tb_degamma_lut_builder;
    import degamma_lut_builder_pkg::*;

    logic       clk;
    logic       rst;
    logic       build_start;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       ready;
    logic       mono_err;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       drop_pulse;

    typedef struct {
        int data;
        int due;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] rom_tbl [TABLE_DEPTH];
    int         exp_tbl [TABLE_DEPTH];
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         cyc    = 0;

    degamma_lut_builder #(
        .DATA_W     (8),
        .AUTO_BUILD (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .build_start (build_start),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .ready       (ready),
        .mono_err    (mono_err),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .drop_pulse  (drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Forward ROM with a registered address, as the parent would provide.
    always @(posedge clk) rom_data <= rom_tbl[rom_addr];

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void load_gamma18();
        real v;
        for (int i = 0; i < TABLE_DEPTH; i++) begin
            v = 255.0 * $pow(i / 255.0, 1.0 / 1.8);
            rom_tbl[i] = 8'(int'($floor(v + 0.5)));
        end
    endfunction

    function automatic void load_half();
        for (int i = 0; i < TABLE_DEPTH; i++) begin
            rom_tbl[i] = 8'(i >> 1);
        end
    endfunction

    // inv[y] = smallest x with G(x) >= y, or the maximum code when no x reaches y
    function automatic void compute_model();
        for (int yy = 0; yy < TABLE_DEPTH; yy++) begin
            exp_tbl[yy] = 255;
            for (int xx = TABLE_DEPTH - 1; xx >= 0; xx--) begin
                if (int'(rom_tbl[xx]) >= yy) exp_tbl[yy] = xx;
            end
        end
    endfunction

    task automatic send(input int d);
        exp_t e;
        in_valid = 1'b1;
        in_data  = 8'(d);
        e.data   = exp_tbl[d];
        e.due    = cyc + 2;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (!ready && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(ready), 1);
    endtask

    task automatic pulse_build();
        build_start = 1'b1;
        @(negedge clk);
        build_start = 1'b0;
    endtask

    // Scoreboard: every out_valid must match the oldest expected pixel, both in value and timing.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            exp_t e;
            check("sb_nonempty_on_out_valid", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("out_data", int'(out_data), e.data);
                check("out_latency", cyc, e.due);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int scen2[6];
        scen2 = '{0, 12, 13, 127, 128, 255};

        rst         = 1'b1;
        build_start = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'd0;
        load_gamma18();
        compute_model();
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_ready", int'(ready), 0);
        check("rst_mono_err", int'(mono_err), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_drop_pulse", int'(drop_pulse), 0);
        check("rst_rom_addr", int'(rom_addr), 0);
        rst = 1'b0;

        // 1: automatic build after reset
        wait_ready(772, "auto_build_ready");
        check("auto_build_mono_err", int'(mono_err), 0);

        // 2: back-to-back lookups
        foreach (scen2[i]) send(scen2[i]);
        idle(4);

        // 3: pixel during a build is dropped, then served after the build
        pulse_build();
        in_valid = 1'b1;
        in_data  = 8'd50;
        #1;
        check("drop_pulse_during_build", int'(drop_pulse), 1);
        check("ready_low_during_build", int'(ready), 0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_ready(800, "rebuild_ready");
        send(50);
        idle(4);

        // 4: rebuild with G(x)=x>>1 requested together with an accepted pixel
        build_start = 1'b1;
        send(128);              // served from the old table
        build_start = 1'b0;
        in_valid    = 1'b0;
        load_half();
        compute_model();
        check("ready_drops_after_start", int'(ready), 0);
        wait_ready(800, "half_build_ready");
        check("half_mono_err", int'(mono_err), 0);
        send(127);
        send(128);
        send(255);
        send(0);
        send(1);
        send(200);
        idle(4);

        // 5: non-monotonic forward table
        load_gamma18();
        rom_tbl[10] = 8'd40;
        rom_tbl[11] = 8'd30;
        pulse_build();
        wait_ready(800, "nonmono_build_ready");
        check("nonmono_mono_err", int'(mono_err), 1);

        // 6a: restart in the middle of a build
        load_gamma18();
        compute_model();
        pulse_build();
        repeat (299) @(negedge clk);
        check("mid_build_not_ready", int'(ready), 0);
        pulse_build();
        wait_ready(800, "restart_ready");
        check("restart_mono_cleared", int'(mono_err), 0);
        foreach (scen2[i]) send(scen2[i]);
        idle(4);

        // 6b: reset in the middle of a build
        pulse_build();
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", int'(ready), 0);
        check("midrst_mono_err", int'(mono_err), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_data", int'(out_data), 0);
        check("midrst_drop_pulse", int'(drop_pulse), 0);
        check("midrst_rom_addr", int'(rom_addr), 0);
        rst = 1'b0;
        wait_ready(772, "post_rst_ready");
        send(50);
        send(200);
        idle(5);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
